// File: rtl/tcdm_stream_pkg.sv
// tcdm_stream_pkg: shared FSM state and TCDM protocol constants
package tcdm_stream_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  localparam logic OPC_READ = 1'b0;
  localparam logic OPC_WRITE = 1'b1;
  localparam logic [3:0] BE_FULL = 4'hF;
endpackage

// File: rtl/tcdm_stream_fifo.sv
// tcdm_stream_fifo: synchronous read-data FIFO with occupancy count
module tcdm_stream_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign empty = count == '0;
  assign rdata = empty ? '0 : mem[rp];
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      assert (!(push && !pop && count == (AW+1)'(DEPTH)));
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/tcdm_stream_reader.sv
// tcdm_stream_reader: strided TCDM read initiator feeding a credit-controlled valid/ready stream
module tcdm_stream_reader
  import tcdm_stream_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [1:0] SRC_ID     = 2'b00,
  parameter int         CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [CNT_W-1:0] n_words,
  input  logic [CNT_W-1:0] stride,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             tcdm_req,
  output logic [29:0]      tcdm_add,
  output logic [3:0]       tcdm_be,
  output logic             tcdm_opc,
  output logic [31:0]      tcdm_wdata,
  output logic [1:0]       tcdm_src_o,
  input  logic             tcdm_gnt,
  input  logic [31:0]      tcdm_rdata,
  input  logic [7:0]       tcdm_err,
  input  logic             tcdm_valid,
  input  logic [1:0]       tcdm_src_i,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  state_t state, state_n;
  logic [31:0] addr;
  logic [CNT_W-1:0] stride_q, n_q, k;
  logic [CW-1:0] outstanding, out_n, fifo_count, cnt_n;
  logic fire, resp, pop, empty, last, accept;
  assign tcdm_be = BE_FULL;
  assign tcdm_opc = OPC_READ;
  assign tcdm_wdata = '0;
  assign tcdm_src_o = SRC_ID;
  assign tcdm_add = addr[31:2];
  assign busy = state != IDLE;
  assign out_valid = !empty;
  assign fire = tcdm_req & tcdm_gnt;
  assign resp = tcdm_valid & (state != IDLE);
  assign pop = out_valid & out_ready;
  assign accept = start & (state == IDLE) & !done;
  assign last = fire & (k == n_q - 1'b1);
  assign out_n = outstanding + CW'(fire) - CW'(resp);
  assign cnt_n = fifo_count + CW'(resp) - CW'(pop);
  always_comb state_n = accept ? (n_words == '0 ? IDLE : ISSUE) :
                        (state == ISSUE && last) ? DRAIN :
                        (state == DRAIN && out_n == '0 && cnt_n == '0) ? IDLE : state;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr <= '0;
      stride_q <= '0;
      n_q <= '0;
      k <= '0;
      outstanding <= '0;
      tcdm_req <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      outstanding <= out_n;
      tcdm_req <= state_n == ISSUE && ({1'b0, out_n} + {1'b0, cnt_n}) < (CW+1)'(FIFO_DEPTH);
      done <= (accept && n_words == '0) || (state == DRAIN && state_n == IDLE);
      if (accept) begin
        addr <= base_addr & 32'hFFFF_FFFC;
        stride_q <= stride;
        n_q <= n_words;
        k <= '0;
        err <= 1'b0;
      end else begin
        if (fire) begin
          addr <= addr + 32'(stride_q);
          k <= k + 1'b1;
        end
        if (resp && (tcdm_err != '0 || tcdm_src_i != SRC_ID)) err <= 1'b1;
      end
    end
  end
  tcdm_stream_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (resp),
    .wdata(tcdm_rdata),
    .pop  (pop),
    .rdata(out_data),
    .empty(empty),
    .count(fifo_count)
  );
endmodule

// File: tb/tb_tcdm_stream_reader.sv
// tb_tcdm_stream_reader: directed self-checking bench for tcdm_stream_reader
module tb_tcdm_stream_reader;
  logic clk = 1'b0;
  logic rst, start, out_ready, tcdm_gnt;
  logic [31:0] base_addr;
  logic [15:0] n_words, stride;
  logic busy, done, err, tcdm_req, tcdm_opc, out_valid, tcdm_valid;
  logic [29:0] tcdm_add;
  logic [3:0] tcdm_be;
  logic [31:0] tcdm_wdata, tcdm_rdata, out_data;
  logic [1:0] tcdm_src_o, tcdm_src_i;
  logic [7:0] tcdm_err;
  logic s_valid = 1'b0, m_valid = 1'b0, inj_err = 1'b0, rand_gnt = 1'b0;
  logic [31:0] s_data = '0;
  int checks = 0, failures = 0, rdy_low = 0, cycles;
  logic [29:0] add_q[$];
  logic [31:0] pop_q[$];
  int req_cnt = 0, gnt_pre_pop = 0, stab_viol = 0;
  logic pend = 1'b0;
  logic [29:0] pend_add = '0;

  always #5 clk = ~clk;

  tcdm_stream_reader #(.FIFO_DEPTH(4), .SRC_ID(2'b00), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .n_words(n_words),
    .stride(stride), .busy(busy), .done(done), .err(err), .tcdm_req(tcdm_req),
    .tcdm_add(tcdm_add), .tcdm_be(tcdm_be), .tcdm_opc(tcdm_opc), .tcdm_wdata(tcdm_wdata),
    .tcdm_src_o(tcdm_src_o), .tcdm_gnt(tcdm_gnt), .tcdm_rdata(tcdm_rdata),
    .tcdm_err(tcdm_err), .tcdm_valid(tcdm_valid), .tcdm_src_i(tcdm_src_i),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  function automatic logic [31:0] dat(input logic [29:0] a);
    return {a, 2'b11} ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk) begin
    s_valid <= tcdm_req && tcdm_gnt;
    s_data <= dat(tcdm_add);
  end
  assign tcdm_valid = s_valid | m_valid;
  assign tcdm_rdata = s_data;
  assign tcdm_err = inj_err ? 8'h01 : 8'h00;
  assign tcdm_src_i = 2'b00;

  always @(negedge clk) begin
    if (tcdm_req) req_cnt++;
    if (tcdm_req && tcdm_gnt) begin
      add_q.push_back(tcdm_add);
      if (pop_q.size() == 0) gnt_pre_pop++;
    end
    if (out_valid && out_ready) pop_q.push_back(out_data);
    if (pend && (!tcdm_req || tcdm_add != pend_add)) stab_viol++;
    pend = tcdm_req && !tcdm_gnt;
    pend_add = tcdm_add;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    add_q.delete();
    pop_q.delete();
    req_cnt = 0;
    gnt_pre_pop = 0;
    stab_viol = 0;
  endtask

  task automatic run_cmd(input logic [31:0] b, input logic [15:0] s, input logic [15:0] n, output int cyc);
    @(posedge clk); #1;
    clr();
    start = 1'b1; base_addr = b; stride = s; n_words = n;
    out_ready = (rdy_low == 0);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        cyc = i;
        break;
      end
      @(posedge clk); #1;
      tcdm_gnt = rand_gnt ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = (i + 1 >= rdy_low);
    end
    tcdm_gnt = 1'b1;
    out_ready = 1'b1;
  endtask

  task automatic check_words(input string tag, input logic [29:0] a0, input int n, input logic [29:0] st);
    logic [29:0] a;
    chk({tag, "_ngnt"}, 32'(add_q.size()), 32'(n));
    chk({tag, "_npop"}, 32'(pop_q.size()), 32'(n));
    for (int i = 0; i < n && i < add_q.size() && i < pop_q.size(); i++) begin
      a = a0 + 30'(i) * st;
      chk({tag, "_add"}, 32'(add_q[i]), 32'(a));
      chk({tag, "_dat"}, pop_q[i], dat(a));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; n_words = '0; stride = '0;
    tcdm_gnt = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_req", 32'(tcdm_req), 0);
    chk("rst_add", 32'(tcdm_add), 0);
    chk("rst_oval", 32'(out_valid), 0);
    chk("rst_odat", out_data, 0);
    chk("const_be", 32'(tcdm_be), 32'hF);
    chk("const_opc", 32'(tcdm_opc), 0);
    chk("const_wdata", tcdm_wdata, 0);
    chk("const_src", 32'(tcdm_src_o), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_cmd(32'h100, 16'd4, 16'd8, cycles);
    chk("t1_cycles", 32'(cycles), 10);
    check_words("t1", 30'h40, 8, 30'd1);
    @(negedge clk);
    chk("t1_done_pulse", 32'(done), 0);
    chk("t1_busy_low", 32'(busy), 0);

    rand_gnt = 1'b1;
    run_cmd(32'h100, 16'd4, 16'd8, cycles);
    rand_gnt = 1'b0;
    chk("t2_finished", 32'(cycles >= 10), 1);
    check_words("t2", 30'h40, 8, 30'd1);
    chk("t2_stable", 32'(stab_viol), 0);

    rdy_low = 20;
    run_cmd(32'h1000, 16'd4, 16'd16, cycles);
    rdy_low = 0;
    chk("t3_finished", 32'(cycles > 20), 1);
    chk("t3_gnt_pre_pop", 32'(gnt_pre_pop), 4);
    check_words("t3", 30'h400, 16, 30'd1);

    run_cmd(32'hFFFF_FFF8, 16'd8, 16'd3, cycles);
    chk("t4_cycles", 32'(cycles), 5);
    check_words("t4", 30'h3FFF_FFFE, 3, 30'd2);

    run_cmd(32'h500, 16'd4, 16'd0, cycles);
    chk("t5_cycles", 32'(cycles), 0);
    chk("t5_no_req", 32'(req_cnt), 0);

    inj_err = 1'b1;
    run_cmd(32'h300, 16'd4, 16'd2, cycles);
    inj_err = 1'b0;
    chk("t6_err_set", 32'(err), 1);
    check_words("t6", 30'hC0, 2, 30'd1);
    run_cmd(32'h300, 16'd4, 16'd0, cycles);
    chk("t6_err_clr", 32'(err), 0);

    @(posedge clk); #1;
    start = 1'b1; base_addr = 32'h2000; stride = 16'd4; n_words = 16'd8;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_valid = 1'b1;
    inj_err = 1'b1;
    @(negedge clk);
    chk("t7_busy", 32'(busy), 0);
    chk("t7_req", 32'(tcdm_req), 0);
    chk("t7_add", 32'(tcdm_add), 0);
    chk("t7_oval", 32'(out_valid), 0);
    chk("t7_odat", out_data, 0);
    chk("t7_done", 32'(done), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_valid = 1'b0;
    inj_err = 1'b0;
    @(negedge clk);
    chk("t7_late_oval", 32'(out_valid), 0);
    chk("t7_late_err", 32'(err), 0);
    run_cmd(32'h200, 16'd4, 16'd4, cycles);
    chk("t7_cycles", 32'(cycles), 6);
    check_words("t7", 30'h80, 4, 30'd1);
    chk("t7_err_after", 32'(err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
